// File: rtl/memory_bus_pkg.sv
// rtl/memory_bus_pkg.sv - shared widths and FSM encoding for the block memory responder
package memory_bus_pkg;

    localparam int addressWidthDefault  = 16;
    localparam int beatWidthDefault     = 32;
    localparam int blockWidthDefault    = 256;
    localparam int beatsPerBlockDefault = blockWidthDefault / beatWidthDefault;
    localparam int beatCountWidth       = 3;

    typedef enum logic [2:0] {
        stateIdle    = 3'd0,
        stateAccess  = 3'd1,
        stateStream  = 3'd2,
        stateCollect = 3'd3,
        stateCommit  = 3'd4
    } memState_t;

endpackage

// File: rtl/block_memory_array.sv
// rtl/block_memory_array.sv - depth x blockWidth synchronous RAM, registered read, no reset
module block_memory_array #(
    parameter int depth      = 256,
    parameter int blockWidth = 256,
    parameter int indexWidth = $clog2(depth)
) (
    input  logic                  clock_i,
    input  logic [indexWidth-1:0] readIndex_i,
    output logic [blockWidth-1:0] readData_o,
    input  logic                  writeEnable_i,
    input  logic [indexWidth-1:0] writeIndex_i,
    input  logic [blockWidth-1:0] writeData_i
);

    logic [blockWidth-1:0] storage [depth];

    always_ff @(posedge clock_i) begin
        if (writeEnable_i) begin
            storage[writeIndex_i] <= writeData_i;
        end
        readData_o <= storage[readIndex_i];
    end

endmodule

// File: rtl/block_memory_responder.sv
// rtl/block_memory_responder.sv - block bus memory responder: 8-beat read stream, 8-beat atomic write
module block_memory_responder
    import memory_bus_pkg::*;
#(
    parameter int addressWidth = addressWidthDefault,
    parameter int databusWidth = beatWidthDefault,
    parameter int blockWidth   = blockWidthDefault,
    parameter int depth        = 256
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    memoryMakeRequest_i,
    input  logic                    isWrite_i,
    input  logic [addressWidth-1:0] address_i,
    input  logic [databusWidth-1:0] memoryDataBus_i,
    output logic [databusWidth-1:0] memoryDataBus_o,
    output logic                    memEnable_o,
    output logic                    isBusy_o,
    output logic                    requestDropped_o
);

    localparam int indexWidth    = $clog2(depth);
    localparam int beatsPerBlock = blockWidth / databusWidth;
    localparam logic [beatCountWidth-1:0] lastBeat = beatCountWidth'(beatsPerBlock - 1);

    memState_t                 state;
    logic [beatCountWidth-1:0] beatCount;
    logic [blockWidth-1:0]     shiftBuffer;
    logic [indexWidth-1:0]     indexReg;
    logic [indexWidth-1:0]     addressIndex;
    logic [blockWidth-1:0]     ramReadData;
    logic                      commitEnable;

    assign addressIndex = indexWidth'(address_i % addressWidth'(depth));

    // The read port samples the live address every cycle; only the sample taken on
    // the request edge is consumed, when ACCESS loads it into the shift buffer.
    assign commitEnable = (state == stateCommit) && reset_i;

    block_memory_array #(
        .depth      (depth),
        .blockWidth (blockWidth),
        .indexWidth (indexWidth)
    ) memoryArray (
        .clock_i       (clock_i),
        .readIndex_i   (addressIndex),
        .readData_o    (ramReadData),
        .writeEnable_i (commitEnable),
        .writeIndex_i  (indexReg),
        .writeData_i   (shiftBuffer)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state            <= stateIdle;
            beatCount        <= '0;
            shiftBuffer      <= '0;
            indexReg         <= '0;
            memoryDataBus_o  <= '0;
            memEnable_o      <= 1'b0;
            isBusy_o         <= 1'b0;
            requestDropped_o <= 1'b0;
        end else begin
            if (memoryMakeRequest_i && (state != stateIdle)) begin
                requestDropped_o <= 1'b1;
            end
            case (state)
                stateIdle: begin
                    memEnable_o     <= 1'b0;
                    memoryDataBus_o <= '0;
                    isBusy_o        <= 1'b0;
                    if (memoryMakeRequest_i) begin
                        isBusy_o <= 1'b1;
                        indexReg <= addressIndex;
                        if (isWrite_i) begin
                            shiftBuffer <= {shiftBuffer[blockWidth-databusWidth-1:0], memoryDataBus_i};
                            beatCount   <= beatCountWidth'(1);
                            state       <= stateCollect;
                        end else begin
                            state <= stateAccess;
                        end
                    end
                end
                stateAccess: begin
                    shiftBuffer <= ramReadData;
                    beatCount   <= '0;
                    state       <= stateStream;
                end
                stateStream: begin
                    // Beat 0 is the most significant word, so the buffer drains from the top.
                    memoryDataBus_o <= shiftBuffer[blockWidth-1 -: databusWidth];
                    memEnable_o     <= 1'b1;
                    shiftBuffer     <= shiftBuffer << databusWidth;
                    beatCount       <= beatCount + beatCountWidth'(1);
                    if (beatCount == lastBeat) begin
                        state <= stateIdle;
                    end
                end
                stateCollect: begin
                    shiftBuffer <= {shiftBuffer[blockWidth-databusWidth-1:0], memoryDataBus_i};
                    beatCount   <= beatCount + beatCountWidth'(1);
                    if (beatCount == lastBeat) begin
                        state <= stateCommit;
                    end
                end
                stateCommit: begin
                    isBusy_o  <= 1'b0;
                    beatCount <= '0;
                    state     <= stateIdle;
                end
                default: begin
                    state <= stateIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_memory_responder.sv
// tb/tb_block_memory_responder.sv - directed self-checking bench for block_memory_responder
module tb_block_memory_responder;

    logic        MEMClock = 1'b0;
    logic        reset_i = 1'b0;
    logic        memoryMakeRequest_i = 1'b0;
    logic        isWrite_i = 1'b0;
    logic [15:0] address_i = '0;
    logic [31:0] memoryDataBus_i = '0;
    logic [31:0] memoryDataBus_o;
    logic        memEnable_o;
    logic        isBusy_o;
    logic        requestDropped_o;

    int total = 0;
    int bad = 0;

    logic [31:0] patA [8];
    logic [31:0] patP [8];
    logic [31:0] patW [8];
    logic [31:0] patQ [8];
    logic [31:0] patR [8];

    block_memory_responder dut (
        .clock_i             (MEMClock),
        .reset_i             (reset_i),
        .memoryMakeRequest_i (memoryMakeRequest_i),
        .isWrite_i           (isWrite_i),
        .address_i           (address_i),
        .memoryDataBus_i     (memoryDataBus_i),
        .memoryDataBus_o     (memoryDataBus_o),
        .memEnable_o         (memEnable_o),
        .isBusy_o            (isBusy_o),
        .requestDropped_o    (requestDropped_o)
    );

    always #5 MEMClock = ~MEMClock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge MEMClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_en"}, {31'd0, memEnable_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, isBusy_o}, 32'd0);
        check({tag, "_data"}, memoryDataBus_o, 32'd0);
    endtask

    task automatic writeBlock(input logic [15:0] addr, input logic [31:0] beats [8], input int resetAt);
        memoryMakeRequest_i = 1'b1;
        isWrite_i = 1'b1;
        address_i = addr;
        memoryDataBus_i = beats[0];
        tick();
        memoryMakeRequest_i = 1'b0;
        check("wr_e0_busy", {31'd0, isBusy_o}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            memoryDataBus_i = beats[k];
            tick();
            check("wr_en_low", {31'd0, memEnable_o}, 32'd0);
            if (k == resetAt) begin
                reset_i = 1'b0;
                tick();
                checkIdleOutputs("wr_reset");
                reset_i = 1'b1;
                return;
            end
        end
        check("wr_e7_busy", {31'd0, isBusy_o}, 32'd1);
        tick();
        check("wr_e8_busy", {31'd0, isBusy_o}, 32'd0);
        check("wr_e8_en", {31'd0, memEnable_o}, 32'd0);
    endtask

    task automatic readBlock(input logic [15:0] addr, input logic [31:0] beats [8],
                             input int interruptAt, input int resetAt);
        memoryMakeRequest_i = 1'b1;
        isWrite_i = 1'b0;
        address_i = addr;
        tick();
        memoryMakeRequest_i = 1'b0;
        check("rd_e0_en", {31'd0, memEnable_o}, 32'd0);
        check("rd_e0_busy", {31'd0, isBusy_o}, 32'd1);
        tick();
        check("rd_e1_en", {31'd0, memEnable_o}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            memoryMakeRequest_i = 1'b0;
            isWrite_i = 1'b0;
            check($sformatf("rd_beat%0d_en", k), {31'd0, memEnable_o}, 32'd1);
            check($sformatf("rd_beat%0d_data", k), memoryDataBus_o, beats[k]);
            check($sformatf("rd_beat%0d_busy", k), {31'd0, isBusy_o}, 32'd1);
            if (k == resetAt) begin
                reset_i = 1'b0;
                tick();
                checkIdleOutputs("rd_reset");
                check("rd_reset_drop", {31'd0, requestDropped_o}, 32'd0);
                reset_i = 1'b1;
                return;
            end
            if (k == interruptAt) begin
                memoryMakeRequest_i = 1'b1;
                isWrite_i = 1'b1;
                address_i = 16'd9;
                memoryDataBus_i = 32'hDEADBEEF;
            end
        end
        tick();
        checkIdleOutputs("rd_e10");
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            patA[k] = 32'h11111111 * (k + 1);
            patP[k] = 32'h90000000 + k;
            patW[k] = 32'hC0DE0000 + k;
            patQ[k] = 32'h0A0A0000 + k;
            patR[k] = 32'h5F5F0000 + k;
        end

        memoryMakeRequest_i = 1'b1;
        isWrite_i = 1'b0;
        tick();
        checkIdleOutputs("reset1");
        check("reset1_drop", {31'd0, requestDropped_o}, 32'd0);
        tick();
        checkIdleOutputs("reset2");
        memoryMakeRequest_i = 1'b0;
        reset_i = 1'b1;
        tick();
        checkIdleOutputs("post_reset");
        check("post_reset_drop", {31'd0, requestDropped_o}, 32'd0);

        // Read issued on the first edge after the write's busy falls.
        writeBlock(16'd5, patA, -1);
        readBlock(16'd5, patA, -1, -1);
        check("no_drop_yet", {31'd0, requestDropped_o}, 32'd0);

        writeBlock(16'd9, patP, -1);
        readBlock(16'd5, patA, 3, -1);
        check("drop_set", {31'd0, requestDropped_o}, 32'd1);
        readBlock(16'd9, patP, -1, -1);
        check("drop_sticky", {31'd0, requestDropped_o}, 32'd1);

        writeBlock(16'h0105, patW, -1);
        readBlock(16'h0005, patW, -1, -1);

        readBlock(16'h0005, patW, -1, 4);
        readBlock(16'h0005, patW, -1, -1);

        writeBlock(16'd7, patQ, -1);
        writeBlock(16'd7, patR, 4);
        readBlock(16'd7, patQ, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_memory_responder.md
# block_memory_responder

Memory-side responder for the core memory controller's block bus. It accepts one request at a time (block address plus read/write flag) and services 256-bit blocks as eight 32-bit beats. Reads are streamed back with `memEnable_o` marking each beat; writes are assembled from eight incoming beats and committed atomically. It sits on the memory side of the controller's `address_o` / `isWrite_o` / `memoryMakeRequest_o` / `memoryDataBus_o` pins and replaces the behavioural memory used in simulation with synthesizable RTL.

## Interface
Parameters:
- `addressWidth`, 16: width of the block address bus.
- `databusWidth`, 32: width of one beat.
- `blockWidth`, 256: block size; beats per block = `blockWidth/databusWidth` = 8.
- `depth`, 256: number of blocks stored; power of two.

Ports:
- `clock_i` in 1: single clock; all logic on the rising edge.
- `reset_i` in 1: synchronous, active-low reset.
- `memoryMakeRequest_i` in 1: request strobe, sampled only in IDLE.
- `isWrite_i` in 1: 1 = write request, 0 = read request; sampled with the request.
- `address_i` in `addressWidth`: block address; index = low log2(`depth`) bits.
- `memoryDataBus_i` in `databusWidth`: write beats.
- `memoryDataBus_o` out `databusWidth`: read beat, registered.
- `memEnable_o` out 1: `memoryDataBus_o` holds a valid read beat.
- `isBusy_o` out 1: a request is in progress.
- `requestDropped_o` out 1: sticky flag; set when a request arrives while busy.

## Operation
- States:
  - IDLE: accepts requests.
  - ACCESS: array read.
  - STREAM: 8 read beats.
  - COLLECT: write beats 1..7.
  - COMMIT: array write.
- Bit order is big-endian `[0:N]`. Beat k occupies block bits `[32k : 32k+31]`, so beat 0 is the most significant word.
- IDLE & request & !isWrite_i: latch the index, go to ACCESS. The array outputs the block into a 256-bit shift buffer, then the state goes to STREAM.
- STREAM: drive beat k with `memEnable_o=1`, shift the buffer, increment the 3-bit beat counter. When the counter wraps 7→0, go to IDLE.
- IDLE & request & isWrite_i: beat 0 is captured from `memoryDataBus_i` on the request edge. Go to COLLECT and capture beats 1..7 on the next 7 edges, then go to COMMIT.
- COMMIT: one full-block array write, then go to IDLE. `memEnable_o` stays 0 for all writes.
- Request outside IDLE: ignored, with no effect on the current transfer. Sets `requestDropped_o`, which clears only on reset.
- Address wrap: index = `address_i mod depth`. Upper address bits are ignored.
- Reset: return to IDLE and clear the counter and buffer. Array contents are not reset. A partial write is discarded and the array is left unchanged.

## Timing
- Reset values: `memoryDataBus_o`=0, `memEnable_o`=0, `isBusy_o`=0, `requestDropped_o`=0. These are reached on the first rising edge with `reset_i`=0.
- Read, with the request sampled at edge E0:
  - ACCESS after E0.
  - Beat 0 valid after E2. Read latency is 2 cycles.
  - Beats 0..7 valid after E2..E9.
  - `memEnable_o` and `isBusy_o` fall at E10. `memoryDataBus_o` returns to 0 when not valid.
- Write, with the request and beat 0 sampled at E0:
  - Beats 1..7 are sampled at E1..E7.
  - The array is written at E8.
  - `isBusy_o` is high from E0 through E8 and falls at E8.
- `isBusy_o` is set on the request edge and is registered.
- Earliest next request: the first edge after `isBusy_o` is observed low.
- Read-after-write: a read issued right after a write returns the newly written block (no stale data).
- Back-to-back: a request held high across the IDLE return is accepted at the first IDLE edge. It is also flagged as dropped if it was sampled high while busy.

## Structure
- Package `memory_bus_pkg` holds:
  - Width constants: address 16, beat 32, block 256, beats 8.
  - The state enum (IDLE, ACCESS, STREAM, COLLECT, COMMIT).
  - The beat-counter width.
- Sub-module `block_memory_array`:
  - `depth` × `blockWidth` synchronous RAM.
  - One registered read port and one write port.
  - No reset.
- The top level holds the FSM, beat counter, shift/collect buffer and flags. Target size is 150–250 RTL lines.

## Test plan
- **Reset:** hold `reset_i`=0 for 2 cycles with the request strobe high. Expect all outputs 0, no transfer started, and `isBusy_o`=0.
- **Write then read, block 5:** write beats 0x11111111..0x88888888, then read block 5. Expect `memEnable_o` high for exactly 8 cycles starting 2 cycles after the request edge, beats in order 0x11111111 first, and `isBusy_o` low after the 8th beat.
- **Request while busy:** mid-read at beat 3, issue a write request to block 9. Expect the read stream unaffected, `requestDropped_o`=1, and block 9 unchanged on a later read.
- **Address wrap:** write to 0x0105, then read 0x0005. Expect the same 8 beats returned.
- **Reset mid-operation:**
  - Reset at read beat 4: outputs are 0 on the next edge, and a new read of the same block returns the full 8 beats.
  - Reset at write beat 4: the old block contents are preserved.
- **Read-after-write:** a read issued on the first edge after the write's `isBusy_o` falls returns the new data, with no stale beat 0.
